// File: rtl/switch_outport_arbiter.sv
// switch_outport_arbiter
//   Output-side allocator for the switch crossbar. Each outport runs a small
//   IDLE/LOCKED state machine. In IDLE it grants inports in round-robin order.
//   A multi-flit packet locks the outport to its owner until the tail flit
//   has been sent. Per-outport/per-VC counters track the free slots in the
//   downstream buffers. A flit is only granted when its VC has at least one
//   credit.
//   Grants are combinational: they come from the registered state and the
//   current requests. All state changes on the rising edge of clk.
module switch_outport_arbiter #(
  parameter int NUM_INPORTS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_SIZE  = 8,
  localparam int IW = (NUM_INPORTS  > 1) ? $clog2(NUM_INPORTS)  : 1,
  localparam int OW = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
  localparam int VW = (NUM_VCS      > 1) ? $clog2(NUM_VCS)      : 1,
  localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                                         clk,
  input  logic                                         nrst,
  input  logic [NUM_INPORTS-1:0]                       i_req,
  input  logic [NUM_INPORTS-1:0][OW-1:0]               i_req_outport,
  input  logic [NUM_INPORTS-1:0][VW-1:0]               i_req_vc,
  input  logic [NUM_INPORTS-1:0]                       i_req_tail,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]         i_credit_return,
  output logic [NUM_INPORTS-1:0]                       o_grant,
  output logic [NUM_OUTPORTS-1:0]                      o_outport_valid,
  output logic [NUM_OUTPORTS-1:0][IW-1:0]              o_outport_sel,
  output logic [NUM_OUTPORTS-1:0][VW-1:0]              o_outport_vc,
  output logic [NUM_OUTPORTS-1:0]                      o_locked,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CW-1:0] o_credits,
  output logic                                         o_credit_overflow
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Per-outport results. The generate blocks below collect them here so
  // that the grant and credit logic can see every outport.
  logic [NUM_OUTPORTS-1:0]                      w_valid;
  logic [NUM_OUTPORTS-1:0][IW-1:0]              w_sel;
  logic [NUM_OUTPORTS-1:0][VW-1:0]              w_vc;
  logic [NUM_OUTPORTS-1:0]                      w_lock;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CW-1:0] w_credits;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]         w_ovf_hit;
  logic                                         r_overflow;

  genvar gi, vi;

  generate
    for (gi = 0; gi < NUM_OUTPORTS; gi++) begin : g_out
      state_t        r_state;
      logic [IW-1:0] r_owner;
      logic [VW-1:0] r_owner_vc;
      logic [IW-1:0] r_rr;
      logic          w_valid_o;
      logic [IW-1:0] w_sel_o;
      logic [VW-1:0] w_vc_o;
      logic          w_tail_o;
      logic [IW-1:0] w_cand;

      // Pick the inport that owns this outport for the current cycle.
      always_comb begin
        w_valid_o = 1'b0;
        w_sel_o   = '0;
        w_vc_o    = '0;
        w_tail_o  = 1'b0;
        w_cand    = '0;
        if (r_state == ST_LOCKED) begin
          // Only the owner may send. The VC latched at the head flit is
          // used, whatever req_vc shows now.
          if (i_req[r_owner] && (i_req_outport[r_owner] == OW'(gi)) &&
              (w_credits[gi][r_owner_vc] != '0)) begin
            w_valid_o = 1'b1;
            w_sel_o   = r_owner;
            w_vc_o    = r_owner_vc;
            w_tail_o  = i_req_tail[r_owner];
          end
        end else begin
          // Round-robin scan. It starts one past the last winner, so the
          // last winner has the lowest priority.
          for (int k = 1; k <= NUM_INPORTS; k++) begin
            w_cand = IW'((int'(r_rr) + k) % NUM_INPORTS);
            if (!w_valid_o && i_req[w_cand] &&
                (i_req_outport[w_cand] == OW'(gi)) &&
                (w_credits[gi][i_req_vc[w_cand]] != '0)) begin
              w_valid_o = 1'b1;
              w_sel_o   = w_cand;
              w_vc_o    = i_req_vc[w_cand];
              w_tail_o  = i_req_tail[w_cand];
            end
          end
        end
        // No flit may move while the block is held in reset.
        if (!nrst) begin
          w_valid_o = 1'b0;
        end
      end

      // Lock state, packet owner and round-robin pointer for this outport.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          r_state    <= ST_IDLE;
          r_owner    <= '0;
          r_owner_vc <= '0;
          r_rr       <= IW'(NUM_INPORTS - 1);
        end else if (w_valid_o) begin
          r_rr <= w_sel_o;
          case (r_state)
            ST_IDLE: begin
              if (!w_tail_o) begin
                r_state    <= ST_LOCKED;
                r_owner    <= w_sel_o;
                r_owner_vc <= w_vc_o;
              end
            end
            ST_LOCKED: begin
              if (w_tail_o) begin
                r_state <= ST_IDLE;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end

      assign w_valid[gi] = w_valid_o;
      assign w_sel[gi]   = w_sel_o;
      assign w_vc[gi]    = w_vc_o;
      assign w_lock[gi]  = (r_state == ST_LOCKED);

      for (vi = 0; vi < NUM_VCS; vi++) begin : g_vc
        logic [CW-1:0] r_cnt;
        logic          w_dec;
        logic          w_inc;

        assign w_dec = w_valid_o && (w_vc_o == VW'(vi));
        assign w_inc = i_credit_return[gi][vi];
        // A return with no matching grant while the counter is already
        // full means the downstream side gave back a credit it never had.
        assign w_ovf_hit[gi][vi] = w_inc && !w_dec && (r_cnt == CW'(BUFFER_SIZE));

        // Downstream credit counter. A grant and a return in the same
        // cycle cancel. A grant needs a nonzero count, so the counter
        // cannot underflow.
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            r_cnt <= CW'(BUFFER_SIZE);
          end else if (w_dec && !w_inc) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_inc && !w_dec && (r_cnt != CW'(BUFFER_SIZE))) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        assign w_credits[gi][vi] = r_cnt;
      end
    end
  endgenerate

  // Sticky overflow flag. Only reset clears it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_overflow <= 1'b0;
    end else if (|w_ovf_hit) begin
      r_overflow <= 1'b1;
    end
  end

  // Each inport targets only one outport, so OR-ing the per-outport
  // grants gives at most one grant per inport.
  always_comb begin
    o_grant = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int i = 0; i < NUM_INPORTS; i++) begin
        if (w_valid[o] && (w_sel[o] == IW'(i))) begin
          o_grant[i] = 1'b1;
        end
      end
    end
  end

  assign o_outport_valid   = w_valid;
  assign o_outport_sel     = w_sel;
  assign o_outport_vc      = w_vc;
  assign o_locked          = w_lock;
  assign o_credits         = w_credits;
  assign o_credit_overflow = r_overflow;

endmodule

// File: tb/tb_switch_outport_arbiter.sv
// Directed bench for switch_outport_arbiter. Inputs change just after the
// rising edge. Outputs are sampled a few ns later, well before the next edge.
module tb_switch_outport_arbiter;

  logic                 clk = 1'b0;
  logic                 nrst = 1'b0;
  logic [3:0]           req = '0;
  logic [3:0][1:0]      req_outport = '0;
  logic [3:0][0:0]      req_vc = '0;
  logic [3:0]           req_tail = '0;
  logic [3:0][1:0]      credit_return = '0;
  logic [3:0]           grant;
  logic [3:0]           outport_valid;
  logic [3:0][1:0]      outport_sel;
  logic [3:0][0:0]      outport_vc;
  logic [3:0]           locked;
  logic [3:0][1:0][3:0] credits;
  logic                 credit_overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_outport_arbiter #(
    .NUM_INPORTS (4),
    .NUM_OUTPORTS(4),
    .NUM_VCS     (2),
    .BUFFER_SIZE (8)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_req            (req),
    .i_req_outport    (req_outport),
    .i_req_vc         (req_vc),
    .i_req_tail       (req_tail),
    .i_credit_return  (credit_return),
    .o_grant          (grant),
    .o_outport_valid  (outport_valid),
    .o_outport_sel    (outport_sel),
    .o_outport_vc     (outport_vc),
    .o_locked         (locked),
    .o_credits        (credits),
    .o_credit_overflow(credit_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("  ok %s = %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_g[4] = '{1, 2, 4, 1};
  int exp_s[4] = '{0, 1, 2, 0};

  initial begin
    // 1: reset. A request is held during reset and must not be granted.
    req[0] = 1'b1;
    req_outport[0] = 2'd0;
    req_tail[0] = 1'b1;
    repeat (2) step();
    for (int o = 0; o < 4; o++) begin
      for (int v = 0; v < 2; v++) begin
        check($sformatf("rst credits[%0d][%0d]", o, v), 32'(credits[o][v]), 8);
      end
    end
    check("rst locked", 32'(locked), 0);
    check("rst grant", 32'(grant), 0);
    check("rst outport_valid", 32'(outport_valid), 0);
    check("rst overflow", 32'(credit_overflow), 0);
    req = '0;
    nrst = 1'b1;
    step();

    // 2: three single-flit requesters on outport 1, VC0, served round-robin.
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1;
      req_outport[i] = 2'd1;
      req_vc[i] = 1'b0;
      req_tail[i] = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr grant c%0d", c + 1), 32'(grant), exp_g[c]);
      check($sformatf("rr sel c%0d", c + 1), 32'(outport_sel[1]), exp_s[c]);
      check($sformatf("rr credits c%0d", c + 1), 32'(credits[1][0]), 8 - c);
      step();
    end
    req = '0;
    #1;
    check("rr credits end", 32'(credits[1][0]), 4);
    check("rr locked", 32'(locked[1]), 0);
    step();

    // 3: a 3-flit packet from inport 2 locks outport 0 against inport 3.
    req[2] = 1'b1; req_outport[2] = 2'd0; req_vc[2] = 1'b0; req_tail[2] = 1'b0;
    req[3] = 1'b1; req_outport[3] = 2'd0; req_vc[3] = 1'b1; req_tail[3] = 1'b1;
    #1;
    check("pkt head grant", 32'(grant), 4);
    check("pkt head locked", 32'(locked[0]), 0);
    step();
    req_vc[2] = 1'b1;  // the owner's VC was latched at the head flit
    #1;
    check("pkt body grant", 32'(grant), 4);
    check("pkt body locked", 32'(locked[0]), 1);
    check("pkt body vc", 32'(outport_vc[0]), 0);
    step();
    req_tail[2] = 1'b1;
    #1;
    check("pkt tail grant", 32'(grant), 4);
    check("pkt tail locked", 32'(locked[0]), 1);
    step();
    req[2] = 1'b0;
    #1;
    check("pkt next grant", 32'(grant), 8);
    check("pkt next vc", 32'(outport_vc[0]), 1);
    check("pkt unlocked", 32'(locked[0]), 0);
    step();
    req = '0;
    #1;
    check("pkt credits vc0", 32'(credits[0][0]), 5);
    check("pkt credits vc1", 32'(credits[0][1]), 7);
    step();

    // 4: drain outport 2 VC1, then a single credit return.
    req[0] = 1'b1; req_outport[0] = 2'd2; req_vc[0] = 1'b1; req_tail[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("drain grant c%0d", c + 1), 32'(grant), 1);
      check($sformatf("drain credits c%0d", c + 1), 32'(credits[2][1]), 8 - c);
      step();
    end
    #1;
    check("empty credits", 32'(credits[2][1]), 0);
    check("empty grant", 32'(grant), 0);
    credit_return[2][1] = 1'b1;
    step();
    credit_return = '0;
    #1;
    check("return credits", 32'(credits[2][1]), 1);
    check("return grant", 32'(grant), 1);
    step();
    #1;
    check("reempty credits", 32'(credits[2][1]), 0);
    check("reempty grant", 32'(grant), 0);
    req = '0;
    step();

    // 5: grant and return together, then an overflowing return.
    req[1] = 1'b1; req_outport[1] = 2'd3; req_vc[1] = 1'b0; req_tail[1] = 1'b1;
    #1;
    check("cr grant", 32'(grant), 2);
    step();
    #1;
    check("cr credits after grant", 32'(credits[3][0]), 7);
    credit_return[3][0] = 1'b1;
    check("cr grant with return", 32'(grant), 2);
    step();
    req = '0;
    #1;
    check("cr credits same-cycle", 32'(credits[3][0]), 7);
    check("cr overflow clear", 32'(credit_overflow), 0);
    step();
    #1;
    check("cr credits refill", 32'(credits[3][0]), 8);
    step();
    credit_return = '0;
    #1;
    check("ovf credits held", 32'(credits[3][0]), 8);
    check("ovf set", 32'(credit_overflow), 1);
    step();
    #1;
    check("ovf sticky", 32'(credit_overflow), 1);

    // 6: reset in the middle of a 4-flit packet.
    req[1] = 1'b1; req_outport[1] = 2'd3; req_vc[1] = 1'b0; req_tail[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("mid grant c%0d", c + 1), 32'(grant), 2);
      step();
    end
    req[0] = 1'b1; req_outport[0] = 2'd3; req_vc[0] = 1'b0; req_tail[0] = 1'b1;
    #1;
    check("mid locked", 32'(locked[3]), 1);
    check("mid credits", 32'(credits[3][0]), 5);
    nrst = 1'b0;
    #1;
    check("arst locked", 32'(locked[3]), 0);
    check("arst credits", 32'(credits[3][0]), 8);
    check("arst grant", 32'(grant), 0);
    check("arst overflow", 32'(credit_overflow), 0);
    nrst = 1'b1;
    #1;
    check("post-rst grant", 32'(grant), 1);
    check("post-rst sel", 32'(outport_sel[3]), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
